wb_stage: RTL and testbench

//   Final (write-back) stage of the 5-stage LoongArch pipeline; consumes the MEM->WB bundle.

---
 rtl/wb_stage_pkg.sv | 46 ++++
 rtl/wb_stage_tlb_ctrl.sv | 69 ++++++
 rtl/wb_stage.sv | 124 ++++++++++++
 tb/tb_wb_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: MEM->WB bundle layout,
// forwarding width, TLB op encodings and the TLB sequencer state type.
package wb_stage_pkg;

    localparam int MEM2WB_LEN = 207;
    localparam int WB_RF_LEN  = 38;

    localparam logic [2:0] TLB_OP_NONE = 3'd0;
    localparam logic [2:0] TLB_OP_SRCH = 3'd1;
    localparam logic [2:0] TLB_OP_RD   = 3'd2;
    localparam logic [2:0] TLB_OP_WR   = 3'd3;
    localparam logic [2:0] TLB_OP_FILL = 3'd4;
    localparam logic [2:0] TLB_OP_INV  = 3'd5;

    // Field order matches the MEM stage packing, first field is the MSB.
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
        logic [2:0]  tlb_op;
        logic [4:0]  invtlb_op;
    } mem2wb_t;

    typedef enum logic [1:0] {
        TLB_IDLE = 2'd0,
        TLB_REQ  = 2'd1,
        TLB_DONE = 2'd2
    } tlb_state_e;

    // Codes 6 and 7 are reserved and behave like "no TLB op".
    function automatic logic tlb_op_defined(input logic [2:0] op);
        return (op >= TLB_OP_SRCH) && (op <= TLB_OP_INV);
    endfunction

endpackage

// File: rtl/wb_stage_tlb_ctrl.sv
// TLB instruction sequencer for WB: IDLE -> REQ (wait for done) -> DONE (retire).
// Produces the stage's ready_go and the request towards the TLB/CSR unit.
module wb_stage_tlb_ctrl
    import wb_stage_pkg::*;
#(
    parameter int TLB_OP_W    = 3,
    parameter int INVTLB_OP_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wb_valid,
    input  logic                   ex,
    input  logic [TLB_OP_W-1:0]    op,
    input  logic [INVTLB_OP_W-1:0] inv_op,
    input  logic                   tlb_op_done,
    output logic                   ready_go,
    output logic                   tlb_op_valid,
    output logic [TLB_OP_W-1:0]    tlb_op,
    output logic [INVTLB_OP_W-1:0] invtlb_op,
    output logic [1:0]             state_dbg
);

    tlb_state_e state;
    tlb_state_e state_nxt;
    logic       op_live;

    // An excepting instruction never talks to the TLB.
    assign op_live = tlb_op_defined(op) & ~ex;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= TLB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ready_go     = ~op_live;
        tlb_op_valid = 1'b0;
        case (state)
            TLB_IDLE: begin
                if (wb_valid & op_live) begin
                    state_nxt = TLB_REQ;
                end
            end
            TLB_REQ: begin
                tlb_op_valid = 1'b1;
                if (tlb_op_done) begin
                    state_nxt = TLB_DONE;
                end
            end
            TLB_DONE: begin
                ready_go  = 1'b1;
                state_nxt = TLB_IDLE;
            end
            default: begin
                state_nxt = TLB_IDLE;
            end
        endcase
    end

    // The bundle cannot change while a request is open, so these stay stable in REQ.
    assign tlb_op    = tlb_op_defined(op) ? op : TLB_OP_NONE;
    assign invtlb_op = inv_op;
    assign state_dbg = state;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/CSR writes, raises exception/ERTN flush, drives trace.
// Define WB_TLB_EN to sequence TLB instructions through wb_stage_tlb_ctrl.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int TLB_OP_W    = 3,
    parameter int INVTLB_OP_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    output logic                   wb_allowin,
    input  logic                   mem_to_wb_valid,
    input  logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic [WB_RF_LEN-1:0]   wb_rf_zip,
    output logic [13:0]            csr_num,
    input  logic [31:0]            csr_rvalue,
    output logic                   csr_we,
    output logic [31:0]            csr_wmask,
    output logic [31:0]            csr_wvalue,
    output logic                   wb_ex,
    output logic [5:0]             wb_ecode,
    output logic [8:0]             wb_esubcode,
    output logic [31:0]            wb_pc,
    output logic [31:0]            wb_vaddr,
    output logic                   ertn_flush,
    output logic                   flush,
    output logic                   tlb_op_valid,
    output logic [TLB_OP_W-1:0]    tlb_op,
    output logic [INVTLB_OP_W-1:0] invtlb_op,
    input  logic                   tlb_op_done,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_we,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata
);

    mem2wb_t     bus;
    logic        wb_valid;
    logic        wb_ready_go;
    logic        commit;
    logic [31:0] final_wdata;

    assign wb_allowin = ~wb_valid | wb_ready_go;

    // A bundle presented while this stage flushes is dropped, not kept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid <= mem_to_wb_valid & ~flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus <= '0;
        end else if (mem_to_wb_valid & wb_allowin) begin
            bus <= mem_to_wb_zip;
        end
    end

    assign wb_ex      = wb_valid & bus.ex;
    assign ertn_flush = wb_valid & bus.ertn & ~bus.ex;
    assign flush      = wb_ex | ertn_flush;

    assign wb_ecode    = bus.ecode;
    assign wb_esubcode = bus.esubcode;
    assign wb_pc       = bus.pc;
    assign wb_vaddr    = bus.vaddr;

    assign commit      = wb_valid & wb_ready_go & ~bus.ex;
    assign final_wdata = bus.csr_read ? csr_rvalue : bus.rf_wdata;

    assign rf_we    = commit & bus.rf_we;
    assign rf_waddr = bus.rf_waddr;
    assign rf_wdata = final_wdata;

    assign wb_rf_zip = {wb_valid & bus.rf_we, bus.rf_waddr, final_wdata};

    assign csr_num    = bus.csr_num;
    assign csr_we     = commit & bus.csr_we;
    assign csr_wmask  = bus.csr_wmask;
    assign csr_wvalue = bus.csr_wvalue;

    assign debug_wb_pc       = bus.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = bus.rf_waddr;
    assign debug_wb_rf_wdata = final_wdata;

`ifdef WB_TLB_EN
    logic [1:0] tlb_state_unused;

    wb_stage_tlb_ctrl #(
        .TLB_OP_W    (TLB_OP_W),
        .INVTLB_OP_W (INVTLB_OP_W)
    ) u_tlb_ctrl (
        .clk          (clk),
        .resetn       (resetn),
        .wb_valid     (wb_valid),
        .ex           (bus.ex),
        .op           (bus.tlb_op),
        .inv_op       (bus.invtlb_op),
        .tlb_op_done  (tlb_op_done),
        .ready_go     (wb_ready_go),
        .tlb_op_valid (tlb_op_valid),
        .tlb_op       (tlb_op),
        .invtlb_op    (invtlb_op),
        .state_dbg    (tlb_state_unused)
    );
`else
    // Without the sequencer, TLB instructions retire as plain single-cycle ops.
    logic unused_tlb;

    assign wb_ready_go  = 1'b1;
    assign tlb_op_valid = 1'b0;
    assign tlb_op       = '0;
    assign invtlb_op    = '0;
    assign unused_tlb   = ^{tlb_op_done, bus.tlb_op, bus.invtlb_op};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboarded GPR commits plus directed flush/CSR/TLB checks.
module tb_wb_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [206:0] mem_to_wb_zip;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [37:0]  wb_rf_zip;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         wb_ex;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [31:0]  wb_pc;
    logic [31:0]  wb_vaddr;
    logic         ertn_flush;
    logic         flush;
    logic         tlb_op_valid;
    logic [2:0]   tlb_op;
    logic [4:0]   invtlb_op;
    logic         tlb_op_done;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_zip     (mem_to_wb_zip),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_rf_zip         (wb_rf_zip),
        .csr_num           (csr_num),
        .csr_rvalue        (csr_rvalue),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .wb_ex             (wb_ex),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_pc             (wb_pc),
        .wb_vaddr          (wb_vaddr),
        .ertn_flush        (ertn_flush),
        .flush             (flush),
        .tlb_op_valid      (tlb_op_valid),
        .tlb_op            (tlb_op),
        .invtlb_op         (invtlb_op),
        .tlb_op_done       (tlb_op_done),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    logic [36:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bundle builder; wmask/wvalue/vaddr/esubcode derive from the other fields.
    function automatic logic [206:0] mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                        input logic [31:0] pc, input logic cr, input logic cw,
                                        input logic [13:0] cn, input logic ex, input logic [5:0] ec,
                                        input logic er, input logic [2:0] op, input logic [4:0] iop);
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [31:0] vaddr;
        logic [8:0]  esub;
        wmask  = 32'h0000_FFFF;
        wvalue = wd ^ 32'h5A5A_0000;
        vaddr  = pc + 32'h40;
        esub   = ex ? 9'h0A5 : 9'h000;
        return {we, wa, wd, pc, cr, cw, cn, wmask, wvalue, vaddr, ex, ec, esub, er, op, iop};
    endfunction

    task automatic issue(input logic [206:0] z, input logic push, input logic [36:0] e, output int waits);
        waits = 0;
        if (push) exp_q.push_back(e);
        mem_to_wb_zip   = z;
        mem_to_wb_valid = 1'b1;
        while (!wb_allowin && waits < 40) begin
            tick();
            waits++;
        end
        if (!wb_allowin) check_val("accept_timeout", 64'(wb_allowin), 1);
        tick();
        mem_to_wb_valid = 1'b0;
    endtask

    always @(negedge clk) begin : rf_monitor
        logic [36:0] e;
        if (resetn === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rf_spurious", 64'(rf_we), 0);
            end else begin
                e = exp_q.pop_front();
                check_val("rf_commit", {rf_waddr, rf_wdata}, e);
                check_val("rf_trace", {debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, {4'hf, e});
            end
        end
    end

    initial begin
        int          w;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;

        resetn          = 1'b0;
        mem_to_wb_valid = 1'b0;
        mem_to_wb_zip   = '0;
        csr_rvalue      = 32'h0000_000B;
        tlb_op_done     = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_allowin", 64'(wb_allowin), 1);
        check_val("rst_rf_we", 64'(rf_we), 0);
        check_val("rst_csr_we", 64'(csr_we), 0);
        check_val("rst_wb_ex", 64'(wb_ex), 0);
        check_val("rst_ertn", 64'(ertn_flush), 0);
        check_val("rst_flush", 64'(flush), 0);
        check_val("rst_tlb_valid", 64'(tlb_op_valid), 0);
        tick();
        resetn = 1'b1;
        tick();

        // add.w: single-cycle commit and forwarding bundle
        issue(mk(1, 5'd5, 32'h1234, 32'h1C00_0000, 0, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0), 1, {5'd5, 32'h1234}, w);
        check_val("add_wait", 64'(w), 0);
        @(negedge clk);
        check_val("add_zip", wb_rf_zip, {1'b1, 5'd5, 32'h1234});
        check_val("add_trace_pc", debug_wb_pc, 32'h1C00_0000);
        tick();
        @(negedge clk);
        check_val("add_pulse_end", 64'(rf_we), 0);

        // csrrd: write data comes from the CSR read port
        issue(mk(1, 5'd7, 32'hDEAD, 32'h1C00_0010, 1, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0), 1, {5'd7, 32'hB}, w);
        @(negedge clk);
        check_val("csrrd_csr_we", 64'(csr_we), 0);
        check_val("csrrd_num", csr_num, 14'h0);
        check_val("csrrd_zip", wb_rf_zip, {1'b1, 5'd7, 32'hB});

        // csrwr commit
        issue(mk(0, 5'd0, 32'h77, 32'h1C00_0020, 0, 1, 14'h5, 0, 6'h0, 0, 3'd0, 5'd0), 0, '0, w);
        @(negedge clk);
        check_val("csrwr_we", 64'(csr_we), 1);
        check_val("csrwr_num", csr_num, 14'h5);
        check_val("csrwr_mask", csr_wmask, 32'h0000_FFFF);
        check_val("csrwr_value", csr_wvalue, 32'h5A5A_0077);

        // exception with a follower presented in the flush cycle
        issue(mk(1, 5'd3, 32'h33, 32'h1C00_0100, 0, 1, 14'h6, 1, 6'h8, 0, 3'd2, 5'd0), 0, '0, w);
        mem_to_wb_zip   = mk(1, 5'd4, 32'h44, 32'h1C00_0104, 0, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0);
        mem_to_wb_valid = 1'b1;
        @(negedge clk);
        check_val("ex_wb_ex", 64'(wb_ex), 1);
        check_val("ex_flush", 64'(flush), 1);
        check_val("ex_ertn", 64'(ertn_flush), 0);
        check_val("ex_rf_we", 64'(rf_we), 0);
        check_val("ex_csr_we", 64'(csr_we), 0);
        check_val("ex_pc", wb_pc, 32'h1C00_0100);
        check_val("ex_ecode", wb_ecode, 6'h8);
        check_val("ex_esub", wb_esubcode, 9'h0A5);
        check_val("ex_vaddr", wb_vaddr, 32'h1C00_0140);
        check_val("ex_allowin", 64'(wb_allowin), 1);
        tick();
        mem_to_wb_valid = 1'b0;
        @(negedge clk);
        check_val("ex_after_wb_ex", 64'(wb_ex), 0);
        check_val("ex_after_flush", 64'(flush), 0);
        check_val("ex_after_rf_we", 64'(rf_we), 0);
        check_val("ex_no_tlb_req", 64'(tlb_op_valid), 0);

        // ertn: one-cycle flush
        issue(mk(0, 5'd0, 32'h0, 32'h1C00_0200, 0, 0, 14'h0, 0, 6'h0, 1, 3'd0, 5'd0), 0, '0, w);
        @(negedge clk);
        check_val("ertn_flush", 64'(ertn_flush), 1);
        check_val("ertn_wb_ex", 64'(wb_ex), 0);
        check_val("ertn_gflush", 64'(flush), 1);
        tick();
        @(negedge clk);
        check_val("ertn_flush_end", 64'(flush), 0);

        // ertn together with ex: the exception wins
        issue(mk(0, 5'd0, 32'h0, 32'h1C00_0300, 0, 0, 14'h0, 1, 6'h3, 1, 3'd0, 5'd0), 0, '0, w);
        @(negedge clk);
        check_val("exertn_ertn", 64'(ertn_flush), 0);
        check_val("exertn_wb_ex", 64'(wb_ex), 1);
        tick();

        // back-to-back accepts with no bubble
        for (int i = 0; i < 3; i++) begin
            issue(mk(1, 5'(10 + i), 32'h100 + 32'(i), 32'h1C00_0400, 0, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0),
                  1, {5'(10 + i), 32'h100 + 32'(i)}, w);
            check_val("b2b_wait", 64'(w), 0);
        end

        // reserved tlb_op: no request, single cycle
        issue(mk(1, 5'd12, 32'h600, 32'h1C00_0500, 0, 0, 14'h0, 0, 6'h0, 0, 3'd6, 5'd0), 1, {5'd12, 32'h600}, w);
        @(negedge clk);
        check_val("op6_tlb_valid", 64'(tlb_op_valid), 0);
        check_val("op6_allowin", 64'(wb_allowin), 1);
        tick();
        @(negedge clk);
        check_val("op6_tlb_valid2", 64'(tlb_op_valid), 0);

        // tlbwr followed by a waiting add
        issue(mk(1, 5'd9, 32'h99, 32'h1C00_0600, 0, 0, 14'h0, 0, 6'h0, 0, 3'd3, 5'd0), 1, {5'd9, 32'h99}, w);
`ifdef WB_TLB_EN
        exp_q.push_back({5'd13, 32'h1313});
        mem_to_wb_zip   = mk(1, 5'd13, 32'h1313, 32'h1C00_0604, 0, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0);
        mem_to_wb_valid = 1'b1;
        @(negedge clk);
        check_val("tlbwr_idle_valid", 64'(tlb_op_valid), 0);
        check_val("tlbwr_idle_allowin", 64'(wb_allowin), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) tlb_op_done = 1'b1;
            @(negedge clk);
            check_val("tlbwr_req_valid", 64'(tlb_op_valid), 1);
            check_val("tlbwr_req_op", tlb_op, 3'd3);
            check_val("tlbwr_req_allowin", 64'(wb_allowin), 0);
        end
        tick();
        tlb_op_done = 1'b0;
        @(negedge clk);
        check_val("tlbwr_done_valid", 64'(tlb_op_valid), 0);
        check_val("tlbwr_done_allowin", 64'(wb_allowin), 1);
        tick();
        mem_to_wb_valid = 1'b0;
        @(negedge clk);
        check_val("tlbwr_next_allowin", 64'(wb_allowin), 1);

        // invtlb: done pulse while IDLE is ignored
        issue(mk(0, 5'd0, 32'h0, 32'h1C00_0700, 0, 0, 14'h0, 0, 6'h0, 0, 3'd5, 5'd3), 0, '0, w);
        tlb_op_done = 1'b1;
        @(negedge clk);
        check_val("inv_idle_valid", 64'(tlb_op_valid), 0);
        tick();
        tlb_op_done = 1'b0;
        @(negedge clk);
        check_val("inv_req_valid", 64'(tlb_op_valid), 1);
        check_val("inv_req_ops", {tlb_op, invtlb_op}, {3'd5, 5'd3});
        tick();
        @(negedge clk);
        check_val("inv_req_hold", 64'(tlb_op_valid), 1);
        tick();
        tlb_op_done = 1'b1;
        tick();
        tlb_op_done = 1'b0;
        @(negedge clk);
        check_val("inv_done_allowin", 64'(wb_allowin), 1);
        check_val("inv_done_valid", 64'(tlb_op_valid), 0);
        tick();

        // reset while a request is open
        issue(mk(1, 5'd14, 32'h1414, 32'h1C00_0800, 0, 0, 14'h0, 0, 6'h0, 0, 3'd4, 5'd0), 0, '0, w);
        tick();
        @(negedge clk);
        check_val("rstreq_valid", 64'(tlb_op_valid), 1);
        tick();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        check_val("rstreq_tlb_valid", 64'(tlb_op_valid), 0);
        check_val("rstreq_allowin", 64'(wb_allowin), 1);
        check_val("rstreq_rf_we", 64'(rf_we), 0);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        check_val("rstreq_after_valid", 64'(tlb_op_valid), 0);
        check_val("rstreq_after_allowin", 64'(wb_allowin), 1);
`else
        check_val("tlbwr_wait", 64'(w), 0);
        @(negedge clk);
        check_val("tlbwr_nop_valid", 64'(tlb_op_valid), 0);
        check_val("tlbwr_nop_op", {tlb_op, invtlb_op}, 8'h00);
        check_val("tlbwr_nop_allowin", 64'(wb_allowin), 1);
`endif
        tick();

        // random traffic with random gaps
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(1, 31));
            wd = $urandom;
            issue(mk(we, wa, wd, 32'h1C00_1000 + 32'(i * 4), 0, 0, 14'h0, 0, 6'h0, 0, 3'd0, 5'd0),
                  we, {wa, wd}, w);
            check_val("rand_wait", 64'(w), 0);
        end

        repeat (3) tick();
        check_val("sb_drain", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
